// File: rtl/acumulador_monedas_if.sv
// Bus between the coin accumulator and its environment: coin levers, purchase
// controls and the change-dispenser handshake.
interface acumulador_monedas_if #(
    parameter int NUM_MONEDAS = 3,
    parameter int ANCHO_SALDO = 5
);
    logic [NUM_MONEDAS-1:0] monedas;
    logic [ANCHO_SALDO-1:0] precio;
    logic                   comprar;
    logic                   borrar;
    logic                   cambio_listo;
    logic [ANCHO_SALDO-1:0] saldo;
    logic                   aceptada;
    logic                   rechazada;
    logic                   moneda_rechazada;
    logic                   cambio_valido;
    logic [ANCHO_SALDO-1:0] cambio;
    logic                   ocupado;

    modport master (
        output monedas, precio, comprar, borrar, cambio_listo,
        input  saldo, aceptada, rechazada, moneda_rechazada, cambio_valido, cambio, ocupado
    );

    modport slave (
        input  monedas, precio, comprar, borrar, cambio_listo,
        output saldo, aceptada, rechazada, moneda_rechazada, cambio_valido, cambio, ocupado
    );
endinterface

// File: rtl/acumulador_monedas.sv
// Coin accumulator for a vending machine: synchronises coin levers, keeps a
// saturating-free balance, sells at a given price and hands out change.
module acumulador_monedas #(
    parameter int NUM_MONEDAS = 3,
    parameter int ANCHO_SALDO = 5,
    parameter int SALDO_MAX   = 12,
    parameter logic [NUM_MONEDAS*ANCHO_SALDO-1:0] VALORES = {5'd10, 5'd5, 5'd1}
) (
    input logic                  clk,
    input logic                  rst_n,
    acumulador_monedas_if.slave  bus
);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        VENTA    = 2'd1,
        DEVOLVER = 2'd2
    } estado_t;

    localparam logic [ANCHO_SALDO:0] MAX_EXT = (ANCHO_SALDO+1)'(SALDO_MAX);

    estado_t                estado_q, estado_d;
    logic [NUM_MONEDAS-1:0] sinc1_q, sinc1_d;
    logic [NUM_MONEDAS-1:0] sinc2_q, sinc2_d;
    logic [NUM_MONEDAS-1:0] previo_q, previo_d;
    logic [ANCHO_SALDO-1:0] saldo_q, saldo_d;
    logic [ANCHO_SALDO-1:0] cambio_q, cambio_d;
    logic [ANCHO_SALDO-1:0] precio_q, precio_d;
    logic                   aceptada_q, aceptada_d;
    logic                   rechazada_q, rechazada_d;
    logic                   moneda_rech_q, moneda_rech_d;
    logic                   cambio_valido_q, cambio_valido_d;
    logic                   ocupado_q, ocupado_d;

    logic [NUM_MONEDAS-1:0] flancos_s;
    logic                   hay_flanco_s;
    logic                   encontrado_s;
    logic                   varios_s;
    logic [ANCHO_SALDO-1:0] valor_s;
    logic [ANCHO_SALDO:0]   suma_s;
    logic [ANCHO_SALDO-1:0] resto_s;

    // State, balance, synchroniser and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q        <= INACTIVO;
            sinc1_q         <= '0;
            sinc2_q         <= '0;
            previo_q        <= '0;
            saldo_q         <= '0;
            cambio_q        <= '0;
            precio_q        <= '0;
            aceptada_q      <= 1'b0;
            rechazada_q     <= 1'b0;
            moneda_rech_q   <= 1'b0;
            cambio_valido_q <= 1'b0;
            ocupado_q       <= 1'b0;
        end else begin
            estado_q        <= estado_d;
            sinc1_q         <= sinc1_d;
            sinc2_q         <= sinc2_d;
            previo_q        <= previo_d;
            saldo_q         <= saldo_d;
            cambio_q        <= cambio_d;
            precio_q        <= precio_d;
            aceptada_q      <= aceptada_d;
            rechazada_q     <= rechazada_d;
            moneda_rech_q   <= moneda_rech_d;
            cambio_valido_q <= cambio_valido_d;
            ocupado_q       <= ocupado_d;
        end
    end

    // Coin edge selection, next-state and next-output logic.
    always_comb begin
        sinc1_d         = bus.monedas;
        sinc2_d         = sinc1_q;
        previo_d        = sinc2_q;
        estado_d        = estado_q;
        saldo_d         = saldo_q;
        cambio_d        = cambio_q;
        precio_d        = precio_q;
        aceptada_d      = 1'b0;
        rechazada_d     = 1'b0;
        moneda_rech_d   = 1'b0;

        flancos_s    = sinc2_q & ~previo_q;
        hay_flanco_s = |flancos_s;
        encontrado_s = 1'b0;
        varios_s     = 1'b0;
        valor_s      = '0;
        // Lowest channel wins; any further simultaneous edge is discarded.
        for (int i = 0; i < NUM_MONEDAS; i++) begin
            if (flancos_s[i]) begin
                if (encontrado_s) begin
                    varios_s = 1'b1;
                end else begin
                    valor_s      = VALORES[i*ANCHO_SALDO +: ANCHO_SALDO];
                    encontrado_s = 1'b1;
                end
            end else begin
                varios_s = varios_s;
            end
        end
        suma_s  = {1'b0, saldo_q} + {1'b0, valor_s};
        resto_s = saldo_q - precio_q;

        case (estado_q)
            INACTIVO: begin
                if (bus.borrar && (saldo_q != '0)) begin
                    cambio_d      = saldo_q;
                    estado_d      = DEVOLVER;
                    moneda_rech_d = hay_flanco_s;
                end else if (bus.comprar) begin
                    moneda_rech_d = hay_flanco_s;
                    if (saldo_q >= bus.precio) begin
                        precio_d = bus.precio;
                        estado_d = VENTA;
                    end else begin
                        rechazada_d = 1'b1;
                    end
                end else if (hay_flanco_s) begin
                    if (suma_s <= MAX_EXT) begin
                        saldo_d       = suma_s[ANCHO_SALDO-1:0];
                        moneda_rech_d = varios_s;
                    end else begin
                        moneda_rech_d = 1'b1;
                    end
                end else begin
                    estado_d = INACTIVO;
                end
            end
            VENTA: begin
                saldo_d       = resto_s;
                aceptada_d    = 1'b1;
                moneda_rech_d = hay_flanco_s;
                if (resto_s != '0) begin
                    cambio_d = resto_s;
                    estado_d = DEVOLVER;
                end else begin
                    estado_d = INACTIVO;
                end
            end
            DEVOLVER: begin
                moneda_rech_d = hay_flanco_s;
                if (bus.cambio_listo) begin
                    saldo_d  = '0;
                    cambio_d = '0;
                    estado_d = INACTIVO;
                end else begin
                    estado_d = DEVOLVER;
                end
            end
            default: begin
                saldo_d  = '0;
                cambio_d = '0;
                estado_d = INACTIVO;
            end
        endcase

        ocupado_d       = (estado_d != INACTIVO);
        cambio_valido_d = (estado_d == DEVOLVER);
    end

    assign bus.saldo            = saldo_q;
    assign bus.cambio           = cambio_q;
    assign bus.aceptada         = aceptada_q;
    assign bus.rechazada        = rechazada_q;
    assign bus.moneda_rechazada = moneda_rech_q;
    assign bus.cambio_valido    = cambio_valido_q;
    assign bus.ocupado          = ocupado_q;

endmodule

// File: tb/tb_acumulador_monedas.sv
// Self-checking bench for acumulador_monedas: a transaction-level model checked
// every cycle, plus literal expectations at key points of directed scenarios.
module tb_acumulador_monedas;

    logic clk;
    logic rst_n;

    acumulador_monedas_if #(.NUM_MONEDAS(3), .ANCHO_SALDO(5)) bus ();

    acumulador_monedas dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: coin values, lever samples from 1/2/3 edges ago, balance.
    int       valor [3] = '{1, 5, 10};
    bit [2:0] hace1, hace2, hace3;
    int       m_saldo, m_cambio, m_precio;
    bit       m_venta_pend, m_devolviendo;
    bit       m_acep, m_rech, m_mrech;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nombre, input int actual, input int esperado);
        n_vec++;
        if (actual != esperado) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nombre, actual, esperado, $time);
        end
    endtask

    // Reference model and per-cycle compare.
    initial begin
        forever begin
            bit [2:0] nuevos;
            int       cuantos;
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                hace1 = 3'b000; hace2 = 3'b000; hace3 = 3'b000;
                m_saldo = 0; m_cambio = 0; m_precio = 0;
                m_venta_pend = 1'b0; m_devolviendo = 1'b0;
                m_acep = 1'b0; m_rech = 1'b0; m_mrech = 1'b0;
            end else begin
                // A coin counts when its lever was low 3 edges ago and high 2 edges ago.
                nuevos  = hace2 & ~hace3;
                cuantos = $countones(nuevos);
                hace3 = hace2; hace2 = hace1; hace1 = bus.monedas;
                m_acep = 1'b0; m_rech = 1'b0; m_mrech = 1'b0;
                if (m_venta_pend) begin
                    m_venta_pend = 1'b0;
                    m_saldo      = m_saldo - m_precio;
                    m_acep       = 1'b1;
                    if (m_saldo > 0) begin
                        m_cambio      = m_saldo;
                        m_devolviendo = 1'b1;
                    end
                    if (cuantos > 0) m_mrech = 1'b1;
                end else if (m_devolviendo) begin
                    if (bus.cambio_listo) begin
                        m_saldo = 0; m_cambio = 0; m_devolviendo = 1'b0;
                    end
                    if (cuantos > 0) m_mrech = 1'b1;
                end else if (bus.borrar && m_saldo > 0) begin
                    m_cambio      = m_saldo;
                    m_devolviendo = 1'b1;
                    if (cuantos > 0) m_mrech = 1'b1;
                end else if (bus.comprar) begin
                    if (m_saldo >= int'(bus.precio)) begin
                        m_precio     = int'(bus.precio);
                        m_venta_pend = 1'b1;
                    end else begin
                        m_rech = 1'b1;
                    end
                    if (cuantos > 0) m_mrech = 1'b1;
                end else if (cuantos > 0) begin
                    int c;
                    c = 0;
                    while (!nuevos[c]) c++;
                    if (cuantos > 1) m_mrech = 1'b1;
                    if (m_saldo + valor[c] <= 12) m_saldo = m_saldo + valor[c];
                    else m_mrech = 1'b1;
                end
            end
            #1;
            chk("saldo", int'(bus.saldo), m_saldo);
            chk("cambio", int'(bus.cambio), m_cambio);
            chk("cambio_valido", int'(bus.cambio_valido), int'(m_devolviendo));
            chk("ocupado", int'(bus.ocupado), int'(m_devolviendo | m_venta_pend));
            chk("aceptada", int'(bus.aceptada), int'(m_acep));
            chk("rechazada", int'(bus.rechazada), int'(m_rech));
            chk("moneda_rechazada", int'(bus.moneda_rechazada), int'(m_mrech));
        end
    end

    task automatic ciclos(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic moneda(input int ch);
        bus.monedas[ch] = 1'b1;
        @(negedge clk);
        bus.monedas[ch] = 1'b0;
        ciclos(4);
    endtask

    task automatic pulso_borrar();
        bus.borrar = 1'b1;
        @(negedge clk);
        bus.borrar = 1'b0;
    endtask

    task automatic pulso_listo();
        bus.cambio_listo = 1'b1;
        @(negedge clk);
        bus.cambio_listo = 1'b0;
    endtask

    task automatic compra(input int p);
        bus.precio  = 5'(p);
        bus.comprar = 1'b1;
        @(negedge clk);
        bus.comprar = 1'b0;
    endtask

    // Directed scenarios with hand-computed literal expectations.
    initial begin
        rst_n            = 1'b1;
        bus.monedas      = 3'b000;
        bus.precio       = 5'd0;
        bus.comprar      = 1'b0;
        bus.borrar       = 1'b0;
        bus.cambio_listo = 1'b0;
        #2 rst_n = 1'b0;
        ciclos(3);
        chk("reset_saldo", int'(bus.saldo), 0);
        chk("reset_ocupado", int'(bus.ocupado), 0);
        rst_n = 1'b1;
        ciclos(2);

        // Fill to the ceiling, then one more coin is refused.
        moneda(1); chk("lit_saldo_5", int'(bus.saldo), 5);
        moneda(1); chk("lit_saldo_10", int'(bus.saldo), 10);
        moneda(0); chk("lit_saldo_11", int'(bus.saldo), 11);
        moneda(0); chk("lit_saldo_12", int'(bus.saldo), 12);
        moneda(0); chk("lit_saldo_tope", int'(bus.saldo), 12);
        pulso_borrar();
        chk("lit_cambio_12", int'(bus.cambio), 12);
        chk("lit_valido_12", int'(bus.cambio_valido), 1);
        ciclos(3);
        chk("lit_cambio_12_held", int'(bus.cambio), 12);
        pulso_listo();
        chk("lit_saldo_vacio", int'(bus.saldo), 0);
        chk("lit_ocupado_vacio", int'(bus.ocupado), 0);

        // Lever held for 10 cycles counts once, after the third edge.
        bus.monedas[0] = 1'b1;
        ciclos(2); chk("lit_latencia_e2", int'(bus.saldo), 0);
        ciclos(1); chk("lit_latencia_e3", int'(bus.saldo), 1);
        ciclos(7);
        bus.monedas[0] = 1'b0;
        ciclos(3); chk("lit_mantenida", int'(bus.saldo), 1);

        // Sale with change: saldo 8, price 6.
        moneda(1); moneda(0); moneda(0);
        chk("lit_saldo_8", int'(bus.saldo), 8);
        compra(6);
        chk("lit_venta_ocupado", int'(bus.ocupado), 1);
        chk("lit_venta_aceptada0", int'(bus.aceptada), 0);
        ciclos(1);
        chk("lit_aceptada", int'(bus.aceptada), 1);
        chk("lit_saldo_2", int'(bus.saldo), 2);
        chk("lit_cambio_2", int'(bus.cambio), 2);
        ciclos(3);
        chk("lit_cambio_2_held", int'(bus.cambio), 2);
        chk("lit_valido_2_held", int'(bus.cambio_valido), 1);
        pulso_listo();
        chk("lit_post_venta_saldo", int'(bus.saldo), 0);
        chk("lit_post_venta_ocupado", int'(bus.ocupado), 0);

        // Insufficient balance.
        moneda(0); moneda(0); moneda(0);
        compra(6);
        chk("lit_rechazada", int'(bus.rechazada), 1);
        chk("lit_rech_saldo", int'(bus.saldo), 3);
        chk("lit_rech_ocupado", int'(bus.ocupado), 0);

        // Refund with a coin arriving during DEVOLVER.
        moneda(0); moneda(0); moneda(0);
        pulso_borrar();
        chk("lit_cambio_6", int'(bus.cambio), 6);
        moneda(1);
        chk("lit_cambio_6_tras_moneda", int'(bus.cambio), 6);
        pulso_listo();
        chk("lit_saldo_0_b", int'(bus.saldo), 0);

        // Two levers together: lowest channel only.
        bus.monedas = 3'b011;
        ciclos(1);
        bus.monedas = 3'b000;
        ciclos(4);
        chk("lit_simultaneas", int'(bus.saldo), 1);

        // Zero-price sales, with and without remainder.
        compra(0); ciclos(1);
        chk("lit_p0_aceptada", int'(bus.aceptada), 1);
        chk("lit_p0_cambio", int'(bus.cambio), 1);
        pulso_listo();
        compra(0); ciclos(1);
        chk("lit_p0_vacio_acep", int'(bus.aceptada), 1);
        chk("lit_p0_vacio_ocup", int'(bus.ocupado), 0);

        // Ignored requests when idle and empty.
        pulso_borrar();
        chk("lit_borrar_vacio", int'(bus.ocupado), 0);
        pulso_listo();
        chk("lit_listo_inactivo", int'(bus.saldo), 0);

        // Ten-unit coin, then an overflowing five.
        moneda(2); chk("lit_saldo_10b", int'(bus.saldo), 10);
        moneda(1); chk("lit_desborde", int'(bus.saldo), 10);

        // Reset in the middle of DEVOLVER acts without a clock edge.
        pulso_borrar();
        chk("lit_cambio_10", int'(bus.cambio), 10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("lit_rst_saldo", int'(bus.saldo), 0);
        chk("lit_rst_valido", int'(bus.cambio_valido), 0);
        chk("lit_rst_ocupado", int'(bus.ocupado), 0);
        chk("lit_rst_cambio", int'(bus.cambio), 0);

        // Lever held across reset release counts as one coin.
        bus.monedas[0] = 1'b1;
        ciclos(3);
        rst_n = 1'b1;
        ciclos(5);
        chk("lit_tras_reset", int'(bus.saldo), 1);
        bus.monedas[0] = 1'b0;
        ciclos(3);
        chk("lit_tras_reset_fin", int'(bus.saldo), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
